// File: rtl/upsizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : upsizer_pkg
// Description : Shared types, group ratio and round-robin helper for the
//               upsizer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package upsizer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int RATIO   = 4;
    localparam int MAX_REQ = 8;

    // First requester at or after last+1 (modulo num_req); returns last when none is set.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         last,
        input int                 num_req
    );
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (int'(last) + i) % num_req;
            if (!found && (i <= num_req) && req[idx]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/upsizer_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : upsizer_rr_arb
// Description : Combinational round-robin picker with its last-grant register.
// Revision    : 1.0 - initial release
// ============================================================================
module upsizer_rr_arb
    import upsizer_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [$clog2(NUM_REQ)-1:0] pick
);

    localparam int c_id_w = $clog2(NUM_REQ);

    logic [c_id_w-1:0]  r_last_grant;
    logic [MAX_REQ-1:0] w_req_ext;
    logic [2:0]         w_pick_ext;

    assign w_req_ext  = MAX_REQ'(req);
    assign w_pick_ext = rr_pick(w_req_ext, 3'(r_last_grant), NUM_REQ);
    assign pick       = c_id_w'(w_pick_ext);

    // Reset value makes requester 0 the first candidate after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_grant <= c_id_w'(NUM_REQ - 1);
        end else if (advance) begin
            r_last_grant <= pick;
        end
    end

endmodule
`default_nettype wire

// File: rtl/upsizer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : upsizer_arbiter
// Description : Grants one requester a whole RATIO-beat group of a shared 4:1
//               upsizer, reports group ownership and checks upsizer out_en.
//               Optional stall flush: UPSZ_ARB_STALL_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module upsizer_arbiter
    import upsizer_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int INP_DATA_WIDTH = 32,
    parameter int DATA_OUT_WIDTH = 128,
    parameter int STALL_TIMEOUT  = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*INP_DATA_WIDTH*8-1:0] req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              up_valid_in,
    output logic [INP_DATA_WIDTH*8-1:0]       up_inp_data,
    input  logic                              up_out_en,
    output logic                              grp_done,
    output logic [$clog2(NUM_REQ)-1:0]        grp_owner,
    output logic                              busy,
    output logic                              seq_err
`ifdef UPSZ_ARB_STALL_FLUSH_EN
    ,
    output logic                              stall_flush
`endif
);

    localparam int c_beat_w = INP_DATA_WIDTH * 8;
    localparam int c_id_w   = $clog2(NUM_REQ);
    localparam int c_ratio  = DATA_OUT_WIDTH / INP_DATA_WIDTH;
    localparam int c_cnt_w  = $clog2(c_ratio);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_ratio - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_cnt_w-1:0]  r_beat_cnt;
    logic [c_id_w-1:0]   r_owner;
    logic [c_id_w-1:0]   w_pick;
    logic                r_grp_done;
    logic [c_id_w-1:0]   r_grp_owner;
    logic                r_seq_err;
    logic                w_advance;
    logic                w_accept;
    logic                w_final;
    logic                w_owner_valid;
    logic [c_beat_w-1:0] w_owner_data;

    assign w_owner_valid = req_valid[r_owner];
    assign w_owner_data  = req_data[int'(r_owner)*c_beat_w +: c_beat_w];

    upsizer_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req_valid),
        .advance (w_advance),
        .pick    (w_pick)
    );

`ifdef UPSZ_ARB_STALL_FLUSH_EN
    localparam int c_stall_w = $clog2(STALL_TIMEOUT + 1);

    logic [c_stall_w-1:0] r_stall_cnt;
    logic                 r_stall_flush;
    logic                 w_stall_idle;
    logic                 w_stall_hit;

    // Only a partially filled group can stall; an untouched grant just waits.
    assign w_stall_idle = (r_state == GRANT) && (r_beat_cnt != '0) && !w_owner_valid;
    assign w_stall_hit  = w_stall_idle && (r_stall_cnt == c_stall_w'(STALL_TIMEOUT - 1));
    assign stall_flush  = r_stall_flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt   <= '0;
            r_stall_flush <= 1'b0;
        end else begin
            r_stall_cnt   <= (w_stall_idle && !w_stall_hit) ? r_stall_cnt + 1'b1 : '0;
            r_stall_flush <= (r_state == FLUSH) && w_final;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        w_accept     = 1'b0;
        w_final      = 1'b0;
        req_ready    = '0;
        up_valid_in  = 1'b0;
        up_inp_data  = '0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_advance    = 1'b1;
                    w_state_next = GRANT;
                end
            end
            GRANT: begin
                req_ready[r_owner] = 1'b1;
                up_valid_in        = w_owner_valid;
                up_inp_data        = w_owner_valid ? w_owner_data : '0;
                w_accept           = w_owner_valid;
                w_final            = w_owner_valid && (r_beat_cnt == c_last_beat);
                if (w_final) begin
                    w_state_next = IDLE;
                end
`ifdef UPSZ_ARB_STALL_FLUSH_EN
                else if (w_stall_hit) begin
                    w_state_next = FLUSH;
                end
`endif
            end
`ifdef UPSZ_ARB_STALL_FLUSH_EN
            FLUSH: begin
                up_valid_in = 1'b1;
                w_accept    = 1'b1;
                w_final     = (r_beat_cnt == c_last_beat);
                if (w_final) begin
                    w_state_next = IDLE;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_owner     <= '0;
            r_grp_done  <= 1'b0;
            r_grp_owner <= '0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grp_done <= w_final;
            r_seq_err  <= r_seq_err | (up_out_en != w_final);
            if (w_advance) begin
                r_owner <= w_pick;
            end
            if (w_accept) begin
                r_beat_cnt <= w_final ? '0 : r_beat_cnt + 1'b1;
            end
            if (w_final) begin
                r_grp_owner <= r_owner;
            end
        end
    end

    assign grp_done  = r_grp_done;
    assign grp_owner = r_grp_owner;
    assign seq_err   = r_seq_err;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_upsizer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_upsizer_arbiter
// Description : Self-checking bench for upsizer_arbiter with a behavioural
//               4:1 upsizer partner and a group scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upsizer_arbiter;
    import upsizer_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int INP     = 32;
    localparam int OUTW    = 128;
    localparam int BW      = INP * 8;
    localparam int IDW     = 2;

    typedef logic [BW-1:0] beat_t;
    typedef struct packed {
        logic [IDW-1:0]    owner;
        logic [4*BW-1:0]   word;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*BW-1:0]   req_data = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    up_valid_in;
    logic [BW-1:0]           up_inp_data;
    logic                    up_out_en;
    logic                    grp_done;
    logic [IDW-1:0]          grp_owner;
    logic                    busy;
    logic                    seq_err;
`ifdef UPSZ_ARB_STALL_FLUSH_EN
    logic                    stall_flush;
`endif
    logic                    force_oe = 1'b0;

    beat_t                   bq [NUM_REQ][$];
    exp_t                    exp_q [$];
    logic [NUM_REQ-1:0]      hs_s = '0;
    int                      up_cnt;
    beat_t                   up_sh [3];
    logic                    nat_oe;
    logic [4*BW-1:0]         cap_word;
    int                      n_vec = 0;
    int                      n_err = 0;
    int                      n_done = 0;

    always #5 clk = ~clk;

    upsizer_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .INP_DATA_WIDTH (INP),
        .DATA_OUT_WIDTH (OUTW),
        .STALL_TIMEOUT  (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .up_valid_in (up_valid_in),
        .up_inp_data (up_inp_data),
        .up_out_en   (up_out_en),
        .grp_done    (grp_done),
        .grp_owner   (grp_owner),
        .busy        (busy),
        .seq_err     (seq_err)
`ifdef UPSZ_ARB_STALL_FLUSH_EN
        ,
        .stall_flush (stall_flush)
`endif
    );

    // Behavioural 4:1 upsizer: out_en on the 4th valid beat, beat 0 at the LSBs.
    assign nat_oe    = up_valid_in && (up_cnt == 3);
    assign up_out_en = nat_oe | force_oe;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            up_cnt <= 0;
        end else if (up_valid_in) begin
            if (up_cnt < 3) up_sh[up_cnt] <= up_inp_data;
            up_cnt <= (up_cnt == 3) ? 0 : up_cnt + 1;
        end
    end

    // Requester sources: handshake sampled mid-cycle, queue popped just after the edge.
    always @(negedge clk) hs_s = req_valid & req_ready;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rstn && hs_s[i] && bq[i].size() > 0) void'(bq[i].pop_front());
            if (bq[i].size() > 0) begin
                req_valid[i]           = 1'b1;
                req_data[i*BW +: BW]   = bq[i][0];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*BW +: BW]   = '0;
            end
        end
    end

    function automatic beat_t mk_beat(input logic [31:0] tag);
        return {8{tag}};
    endfunction

    function automatic logic [4*BW-1:0] mk_word(input logic [31:0] tag);
        return {mk_beat(tag + 32'd3), mk_beat(tag + 32'd2), mk_beat(tag + 32'd1), mk_beat(tag)};
    endfunction

    task automatic push_beats(input int id, input logic [31:0] tag, input int n);
        for (int k = 0; k < n; k++) bq[id].push_back(mk_beat(tag + 32'(k)));
    endtask

    task automatic push_exp(input int owner, input logic [4*BW-1:0] word);
        exp_t e;
        e.owner = IDW'(owner);
        e.word  = word;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        force_oe = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) bq[i].delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic sb_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (nat_oe) cap_word = {up_inp_data, up_sh[2], up_sh[1], up_sh[0]};
                if (grp_done) begin
                    n_done++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected_group: owner=%0d completed, required no group", grp_owner);
                    end else begin
                        e = exp_q.pop_front();
                        if (grp_owner !== e.owner) begin
                            n_err++;
                            $display("FAIL sb_owner: got %0d, required %0d", grp_owner, e.owner);
                        end
                        n_vec++;
                        if (cap_word !== e.word) begin
                            n_err++;
                            $display("FAIL sb_word: got beats %h %h %h %h, required %h %h %h %h",
                                     cap_word[3*BW +: 32], cap_word[2*BW +: 32], cap_word[BW +: 32], cap_word[31:0],
                                     e.word[3*BW +: 32], e.word[2*BW +: 32], e.word[BW +: 32], e.word[31:0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++; if (req_ready !== '0)   begin n_err++; $display("FAIL rst_req_ready: got %b, required 000", req_ready); end
        n_vec++; if (up_valid_in !== 0)  begin n_err++; $display("FAIL rst_up_valid_in: got %b, required 0", up_valid_in); end
        n_vec++; if (up_inp_data !== '0) begin n_err++; $display("FAIL rst_up_inp_data: got nonzero, required 0"); end
        n_vec++; if (grp_done !== 0)     begin n_err++; $display("FAIL rst_grp_done: got %b, required 0", grp_done); end
        n_vec++; if (grp_owner !== '0)   begin n_err++; $display("FAIL rst_grp_owner: got %0d, required 0", grp_owner); end
        n_vec++; if (busy !== 0)         begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_vec++; if (seq_err !== 0)      begin n_err++; $display("FAIL rst_seq_err: got %b, required 0", seq_err); end
`ifdef UPSZ_ARB_STALL_FLUSH_EN
        n_vec++; if (stall_flush !== 0)  begin n_err++; $display("FAIL rst_stall_flush: got %b, required 0", stall_flush); end
`endif
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_stream();
        int rdy = 0, bubble = 0, bad = 0, done0;
        bit seen = 0;
        apply_reset();
        done0 = n_done;
        push_beats(1, 32'hA000_0000, 2 * RATIO);
        push_exp(1, mk_word(32'hA000_0000));
        push_exp(1, mk_word(32'hA000_0004));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready == 3'b010) begin
                rdy++;
                seen = 1;
            end else if (req_ready != 3'b000) begin
                bad++;
            end else if (seen && rdy < 8) begin
                bubble++;
            end
        end
        n_vec++; if (rdy != 8)              begin n_err++; $display("FAIL s1_ready_cycles: got %0d, required 8", rdy); end
        n_vec++; if (bubble != 1)           begin n_err++; $display("FAIL s1_bubble: got %0d, required 1", bubble); end
        n_vec++; if (bad != 0)              begin n_err++; $display("FAIL s1_foreign_ready: got %0d cycles, required 0", bad); end
        n_vec++; if (n_done - done0 != 2)   begin n_err++; $display("FAIL s1_groups: got %0d, required 2", n_done - done0); end
        n_vec++; if (seq_err !== 0)         begin n_err++; $display("FAIL s1_seq_err: got %b, required 0", seq_err); end
    endtask

    task automatic test_round_robin();
        int bad = 0, done0;
        apply_reset();
        done0 = n_done;
        push_beats(0, 32'hB000_0000, 2 * RATIO);
        push_beats(1, 32'hC000_0000, RATIO);
        push_beats(2, 32'hD000_0000, RATIO);
        push_exp(0, mk_word(32'hB000_0000));
        push_exp(1, mk_word(32'hC000_0000));
        push_exp(2, mk_word(32'hD000_0000));
        push_exp(0, mk_word(32'hB000_0004));
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!$onehot0(req_ready)) bad++;
        end
        n_vec++; if (bad != 0)              begin n_err++; $display("FAIL rr_ready_onehot: got %0d bad cycles, required 0", bad); end
        n_vec++; if (n_done - done0 != 4)   begin n_err++; $display("FAIL rr_groups: got %0d, required 4", n_done - done0); end
        n_vec++; if (exp_q.size() != 0)     begin n_err++; $display("FAIL rr_pending: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_drop_valid();
        int bad = 0, done0, t = 0;
        done0 = n_done;
        push_beats(2, 32'hE000_0000, 2);
        push_exp(2, mk_word(32'hE000_0000));
        while (bq[2].size() != 0 && t < 12) begin
            @(negedge clk);
            t++;
        end
        n_vec++; if (bq[2].size() != 0)     begin n_err++; $display("FAIL dv_first_beats: got %0d left, required 0", bq[2].size()); end
        push_beats(0, 32'hF000_0000, RATIO);
        push_beats(1, 32'h9000_0000, RATIO);
        push_exp(0, mk_word(32'hF000_0000));
        push_exp(1, mk_word(32'h9000_0000));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (req_ready !== 3'b100 || up_valid_in !== 0 || busy !== 1) bad++;
        end
        n_vec++; if (bad != 0)              begin n_err++; $display("FAIL dv_hold: got %0d bad cycles, required 0", bad); end
        push_beats(2, 32'hE000_0002, 2);
        repeat (30) @(negedge clk);
        n_vec++; if (n_done - done0 != 3)   begin n_err++; $display("FAIL dv_groups: got %0d, required 3", n_done - done0); end
    endtask

    task automatic test_reset_mid_group();
        int t = 0, done0;
        push_beats(2, 32'h7000_0000, RATIO);
        while (bq[2].size() != 1 && t < 12) begin
            @(negedge clk);
            t++;
        end
        n_vec++; if (bq[2].size() != 1)     begin n_err++; $display("FAIL rm_three_beats: got %0d left, required 1", bq[2].size()); end
        #2 rstn = 1'b0;
        #1;
        n_vec++; if (req_ready !== '0 || up_valid_in !== 0 || up_inp_data !== '0 || busy !== 0 || grp_done !== 0) begin
            n_err++;
            $display("FAIL rm_async_clear: got ready=%b valid=%b busy=%b done=%b, required all 0", req_ready, up_valid_in, busy, grp_done);
        end
        for (int i = 0; i < NUM_REQ; i++) bq[i].delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        done0 = n_done;
        push_beats(0, 32'h5000_0000, RATIO);
        push_beats(2, 32'h6000_0000, RATIO);
        push_exp(0, mk_word(32'h5000_0000));
        push_exp(2, mk_word(32'h6000_0000));
        t = 0;
        while (busy !== 1 && t < 8) begin
            @(negedge clk);
            t++;
        end
        n_vec++; if (req_ready !== 3'b001)  begin n_err++; $display("FAIL rm_first_owner: got %b, required 001", req_ready); end
        repeat (20) @(negedge clk);
        n_vec++; if (n_done - done0 != 2)   begin n_err++; $display("FAIL rm_groups: got %0d, required 2", n_done - done0); end
        n_vec++; if (seq_err !== 0)         begin n_err++; $display("FAIL rm_seq_err: got %b, required 0", seq_err); end
    endtask

    task automatic test_seq_err();
        int t = 0;
        push_beats(1, 32'h3000_0000, RATIO);
        push_exp(1, mk_word(32'h3000_0000));
        n_vec++; if (seq_err !== 0)         begin n_err++; $display("FAIL se_before: got %b, required 0", seq_err); end
        while (up_valid_in !== 1 && t < 8) begin
            @(negedge clk);
            t++;
        end
        force_oe = 1'b1;
        @(negedge clk);
        force_oe = 1'b0;
        n_vec++; if (seq_err !== 1)         begin n_err++; $display("FAIL se_set: got %b, required 1", seq_err); end
        repeat (15) @(negedge clk);
        n_vec++; if (seq_err !== 1)         begin n_err++; $display("FAIL se_sticky: got %b, required 1", seq_err); end
        apply_reset();
        n_vec++; if (seq_err !== 0)         begin n_err++; $display("FAIL se_cleared: got %b, required 0", seq_err); end
    endtask

`ifdef UPSZ_ARB_STALL_FLUSH_EN
    task automatic test_stall_flush();
        int gap = 0, zbeats = 0, sf = 0, sf_bad = 0, done0;
        apply_reset();
        done0 = n_done;
        push_beats(0, 32'h4000_0000, 1);
        push_exp(0, {{3{beat_t'(0)}}, mk_beat(32'h4000_0000)});
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy && !up_valid_in) gap++;
            if (busy && up_valid_in && req_ready == '0 && up_inp_data == '0) zbeats++;
            if (stall_flush) sf++;
            if (stall_flush !== grp_done) sf_bad++;
        end
        n_vec++; if (gap != 16)             begin n_err++; $display("FAIL sf_idle_cycles: got %0d, required 16", gap); end
        n_vec++; if (zbeats != 3)           begin n_err++; $display("FAIL sf_zero_beats: got %0d, required 3", zbeats); end
        n_vec++; if (sf != 1)               begin n_err++; $display("FAIL sf_pulses: got %0d, required 1", sf); end
        n_vec++; if (sf_bad != 0)           begin n_err++; $display("FAIL sf_coincident: got %0d cycles apart, required 0", sf_bad); end
        n_vec++; if (n_done - done0 != 1)   begin n_err++; $display("FAIL sf_groups: got %0d, required 1", n_done - done0); end
        n_vec++; if (seq_err !== 0)         begin n_err++; $display("FAIL sf_seq_err: got %b, required 0", seq_err); end
    endtask
`endif

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_single_stream();
        test_round_robin();
        test_drop_valid();
        test_reset_mid_group();
        test_seq_err();
`ifdef UPSZ_ARB_STALL_FLUSH_EN
        test_stall_flush();
`endif
        repeat (4) @(negedge clk);
        n_vec++; if (exp_q.size() != 0)     begin n_err++; $display("FAIL sb_leftover: got %0d pending groups, required 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
